// File: rtl/hysteresis_counter_pkg.sv
// Shared hysteresis step rule and flush FSM states for the counter table.
// Purely combinational helpers; no latency or backpressure of their own.
package hysteresis_counter_pkg;

  localparam int unsigned HC_RANGE      = 4;
  localparam int unsigned HC_COERCIVITY = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // Crossing the midpoint jumps by COERCIVITY so a single opposing event cannot flip the prediction.
  function automatic int unsigned hysteresis_next(
    input int unsigned count,
    input logic        inc,
    input logic        dec,
    input int unsigned range      = HC_RANGE,
    input int unsigned coercivity = HC_COERCIVITY
  );
    int unsigned half_low;
    int unsigned half_high;
    int unsigned result;
    half_low  = range / 2 - 1;
    half_high = range / 2;
    result    = count;
    if (inc && !dec && count != range - 1) begin
      result = (count == half_low) ? half_high + coercivity : count + 1;
    end else if (dec && !inc && count != 0) begin
      result = (count == half_high) ? half_low - coercivity : count - 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hysteresis_counter_array.sv
// Table of hysteresis counters with one read and one update port; reads return one cycle later, write-first.
// ready drops for exactly DEPTH cycles during a walking flush; requests offered while not ready are dropped.
module hysteresis_counter_array
  import hysteresis_counter_pkg::*;
#(
  parameter  int unsigned DEPTH       = 16,
  parameter  int unsigned RANGE       = 4,
  parameter  int unsigned RESET_VALUE = 1,
  parameter  int unsigned COERCIVITY  = 1,
  localparam int unsigned IW          = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int unsigned W           = $clog2(RANGE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  output logic          ready,
  input  logic          read_enable,
  input  logic [IW-1:0] read_index,
  output logic          read_valid,
  output logic [W-1:0]  read_count,
  output logic          read_prediction,
  input  logic          update_enable,
  input  logic [IW-1:0] update_index,
  input  logic          update_increment,
  input  logic          update_decrement
);

  localparam logic [W-1:0]  RESET_VALUE_W = W'(RESET_VALUE);
  localparam logic [W-1:0]  HALF_HIGH_W   = W'(RANGE / 2);
  localparam logic [IW:0]   DEPTH_EXT     = (IW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX      = IW'(DEPTH - 1);

  logic [W-1:0]  entries_q [DEPTH];
  logic [W-1:0]  entries_d [DEPTH];
  flush_state_t  state_q, state_d;
  logic [IW-1:0] flush_idx_q, flush_idx_d;
  logic          read_valid_q, read_valid_d;
  logic [W-1:0]  read_count_q, read_count_d;
  logic          read_prediction_q, read_prediction_d;

  logic          update_hit;
  logic          read_hit;
  logic          read_in_range;

  assign ready           = (state_q == IDLE);
  assign read_valid      = read_valid_q;
  assign read_count      = read_count_q;
  assign read_prediction = read_prediction_q;

  assign update_hit    = update_enable && ready && ({1'b0, update_index} < DEPTH_EXT);
  assign read_hit      = read_enable && ready;
  assign read_in_range = ({1'b0, read_index} < DEPTH_EXT);

  always_comb begin
    entries_d = entries_q;
    if (update_hit) begin
      entries_d[update_index] = W'(hysteresis_next(32'(entries_q[update_index]),
                                                   update_increment, update_decrement,
                                                   RANGE, COERCIVITY));
    end
    if (state_q == FLUSH) begin
      entries_d[flush_idx_q] = RESET_VALUE_W;
    end
  end

  // Read sees entries_d so an update to the same index in the same cycle is visible.
  always_comb begin
    read_valid_d      = 1'b0;
    read_count_d      = read_count_q;
    read_prediction_d = read_prediction_q;
    if (read_hit) begin
      read_valid_d      = 1'b1;
      read_count_d      = read_in_range ? entries_d[read_index] : RESET_VALUE_W;
      read_prediction_d = (read_count_d >= HALF_HIGH_W);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        flush_idx_d = flush_idx_q + IW'(1);
        if (flush_idx_q == LAST_IDX) begin
          state_d     = IDLE;
          flush_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= RESET_VALUE_W;
      end
      state_q           <= IDLE;
      flush_idx_q       <= '0;
      read_valid_q      <= 1'b0;
      read_count_q      <= '0;
      read_prediction_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= entries_d[i];
      end
      state_q           <= state_d;
      flush_idx_q       <= flush_idx_d;
      read_valid_q      <= read_valid_d;
      read_count_q      <= read_count_d;
      read_prediction_q <= read_prediction_d;
    end
  end

endmodule
